// File: rtl/reg_file_wb.sv
// Write-back register file: 16 x 16-bit storage, two registered read ports with
// same-edge write bypass, and a debug dump engine that streams all registers out.
module reg_file_wb #(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_DM_WB,
  input  logic [3:0]  dst_addr_DM_WB,
  input  logic [15:0] rf_w_data_DM_WB,
  input  logic [3:0]  p0_addr,
  input  logic [3:0]  p1_addr,
  input  logic        re0,
  input  logic        re1,
  input  logic        stall,
  output logic [15:0] p0,
  output logic [15:0] p1,
  input  logic        dbg_req,
  output logic        dbg_busy,
  output logic        dbg_vld,
  output logic [3:0]  dbg_idx,
  output logic [15:0] dbg_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [15:0] regs_q [16];
  logic        wrEn;

  logic [15:0] p0_q, p0_d;
  logic [15:0] p1_q, p1_d;

  logic [0:0]  state_q, state_d;
  logic [3:0]  scanCnt_q, scanCnt_d;
  logic        dbgVld_q, dbgVld_d;
  logic [3:0]  dbgIdx_q, dbgIdx_d;
  logic [15:0] dbgData_q, dbgData_d;

  // Register 0 is hardwired to zero when R0_ZERO is set, so its writes are dropped.
  assign wrEn = we_DM_WB && !(R0_ZERO && (dst_addr_DM_WB == 4'd0));

  function automatic logic [15:0] readPort(input logic [3:0] idx);
    if (R0_ZERO && (idx == 4'd0)) begin
      return 16'h0000;
    end else if (wrEn && (dst_addr_DM_WB == idx)) begin
      return rf_w_data_DM_WB;
    end else begin
      return regs_q[idx];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (wrEn) begin
      regs_q[dst_addr_DM_WB] <= rf_w_data_DM_WB;
    end
  end

  always_comb begin
    p0_d = p0_q;
    p1_d = p1_q;
    if (re0 && !stall) begin
      p0_d = readPort(p0_addr);
    end
    if (re1 && !stall) begin
      p1_d = readPort(p1_addr);
    end
  end

  // The exit edge returns to IDLE without looking at dbg_req, so a request held
  // across the last word only starts a new scan one edge later.
  always_comb begin
    state_d   = state_q;
    scanCnt_d = scanCnt_q;
    dbgVld_d  = 1'b0;
    dbgIdx_d  = dbgIdx_q;
    dbgData_d = dbgData_q;
    if (state_q == IDLE) begin
      if (dbg_req) begin
        state_d   = SCAN;
        scanCnt_d = 4'd0;
      end
    end else begin
      dbgVld_d  = 1'b1;
      dbgIdx_d  = scanCnt_q;
      dbgData_d = readPort(scanCnt_q);
      scanCnt_d = scanCnt_q + 4'd1;
      if (scanCnt_q == 4'd15) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q      <= 16'h0000;
      p1_q      <= 16'h0000;
      state_q   <= IDLE;
      scanCnt_q <= 4'd0;
      dbgVld_q  <= 1'b0;
      dbgIdx_q  <= 4'd0;
      dbgData_q <= 16'h0000;
    end else begin
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      state_q   <= state_d;
      scanCnt_q <= scanCnt_d;
      dbgVld_q  <= dbgVld_d;
      dbgIdx_q  <= dbgIdx_d;
      dbgData_q <= dbgData_d;
    end
  end

  assign p0       = p0_q;
  assign p1       = p1_q;
  assign dbg_busy = (state_q == SCAN);
  assign dbg_vld  = dbgVld_q;
  assign dbg_idx  = dbgIdx_q;
  assign dbg_data = dbgData_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: a reference model pushes expected per-cycle
// outputs and dump words when stimulus is driven; they are popped after each edge.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        we_DM_WB;
  logic [3:0]  dst_addr_DM_WB;
  logic [15:0] rf_w_data_DM_WB;
  logic [3:0]  p0_addr;
  logic [3:0]  p1_addr;
  logic        re0;
  logic        re1;
  logic        stall;
  logic [15:0] p0;
  logic [15:0] p1;
  logic        dbg_req;
  logic        dbg_busy;
  logic        dbg_vld;
  logic [3:0]  dbg_idx;
  logic [15:0] dbg_data;

  reg_file_wb dut (
    .clk             (clk),
    .rst             (rst),
    .we_DM_WB        (we_DM_WB),
    .dst_addr_DM_WB  (dst_addr_DM_WB),
    .rf_w_data_DM_WB (rf_w_data_DM_WB),
    .p0_addr         (p0_addr),
    .p1_addr         (p1_addr),
    .re0             (re0),
    .re1             (re1),
    .stall           (stall),
    .p0              (p0),
    .p1              (p1),
    .dbg_req         (dbg_req),
    .dbg_busy        (dbg_busy),
    .dbg_vld         (dbg_vld),
    .dbg_idx         (dbg_idx),
    .dbg_data        (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic        vld;
    logic        busy;
  } cycleExp_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } dumpExp_t;

  cycleExp_t   expQ[$];
  dumpExp_t    dumpQ[$];

  logic [15:0] modelRegs [16];
  logic [15:0] modelP0;
  logic [15:0] modelP1;
  logic [3:0]  lastIdx;
  logic [15:0] lastData;
  int          scanLeft;
  int          compared;
  int          mismatched;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [3:0] a, input logic wEff,
                                           input logic [3:0] dst, input logic [15:0] wdata);
    if (a == 4'd0) return 16'h0000;
    if (wEff && (dst == a)) return wdata;
    return modelRegs[a];
  endfunction

  task automatic checkCycle();
    cycleExp_t e;
    dumpExp_t  w;
    e = expQ.pop_front();
    checkOutput("p0", 32'(p0), 32'(e.p0));
    checkOutput("p1", 32'(p1), 32'(e.p1));
    checkOutput("dbg_vld", 32'(dbg_vld), 32'(e.vld));
    checkOutput("dbg_busy", 32'(dbg_busy), 32'(e.busy));
    if (e.vld) begin
      if (dumpQ.size() > 0) begin
        w = dumpQ.pop_front();
        checkOutput("dbg_idx", 32'(dbg_idx), 32'(w.idx));
        checkOutput("dbg_data", 32'(dbg_data), 32'(w.data));
        lastIdx  = w.idx;
        lastData = w.data;
      end else begin
        checkOutput("dump_queue_underrun", 32'd0, 32'd1);
      end
    end else begin
      checkOutput("dbg_idx_hold", 32'(dbg_idx), 32'(lastIdx));
      checkOutput("dbg_data_hold", 32'(dbg_data), 32'(lastData));
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] dst, input logic [15:0] wdata,
                               input logic r0, input logic [3:0] a0,
                               input logic r1, input logic [3:0] a1,
                               input logic st, input logic req);
    cycleExp_t e;
    dumpExp_t  w;
    logic      wEff;
    logic      scanStart;
    @(negedge clk);
    we_DM_WB        = we;
    dst_addr_DM_WB  = dst;
    rf_w_data_DM_WB = wdata;
    re0             = r0;
    p0_addr         = a0;
    re1             = r1;
    p1_addr         = a1;
    stall           = st;
    dbg_req         = req;

    wEff      = we && (dst != 4'd0);
    scanStart = 1'b0;
    e.p0      = (r0 && !st) ? modelRead(a0, wEff, dst, wdata) : modelP0;
    e.p1      = (r1 && !st) ? modelRead(a1, wEff, dst, wdata) : modelP1;
    modelP0   = e.p0;
    modelP1   = e.p1;
    e.vld     = (scanLeft > 0);
    if (scanLeft > 0) begin
      scanLeft--;
    end else if (req) begin
      scanLeft  = 16;
      scanStart = 1'b1;
    end
    e.busy = (scanLeft > 0);
    if (wEff) modelRegs[dst] = wdata;
    if (scanStart) begin
      for (int i = 0; i < 16; i++) begin
        w.idx  = 4'(i);
        w.data = (i == 0) ? 16'h0000 : modelRegs[i];
        dumpQ.push_back(w);
      end
    end
    expQ.push_back(e);

    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic idleCycle(input logic req);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, req);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) modelRegs[i] = 16'h0000;
    modelP0  = 16'h0000;
    modelP1  = 16'h0000;
    lastIdx  = 4'd0;
    lastData = 16'h0000;
    scanLeft = 0;
    dumpQ.delete();
    expQ.delete();
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, "_p0"}, 32'(p0), 32'd0);
    checkOutput({phase, "_p1"}, 32'(p1), 32'd0);
    checkOutput({phase, "_dbg_vld"}, 32'(dbg_vld), 32'd0);
    checkOutput({phase, "_dbg_busy"}, 32'(dbg_busy), 32'd0);
    checkOutput({phase, "_dbg_idx"}, 32'(dbg_idx), 32'd0);
    checkOutput({phase, "_dbg_data"}, 32'(dbg_data), 32'd0);
  endtask

  // Asynchronous reset between clock edges, with a write and read attempted under reset.
  task automatic resetPulse();
    #2;
    rst             = 1'b1;
    we_DM_WB        = 1'b1;
    dst_addr_DM_WB  = 4'd2;
    rf_w_data_DM_WB = 16'h5555;
    re0             = 1'b1;
    p0_addr         = 4'd3;
    stall           = 1'b0;
    dbg_req         = 1'b0;
    #1;
    checkAllZero("async_rst");
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("rst_reg%0d", i), 32'(dut.regs_q[i]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("held_rst");
    @(negedge clk);
    rst      = 1'b0;
    we_DM_WB = 1'b0;
    re0      = 1'b0;
    clearModel();
  endtask

  initial begin
    logic reached;
    compared        = 0;
    mismatched      = 0;
    rst             = 1'b1;
    we_DM_WB        = 1'b0;
    dst_addr_DM_WB  = 4'd0;
    rf_w_data_DM_WB = 16'h0000;
    p0_addr         = 4'd0;
    p1_addr         = 4'd0;
    re0             = 1'b0;
    re1             = 1'b0;
    stall           = 1'b0;
    dbg_req         = 1'b0;
    clearModel();

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] write then read, bypass, r0 and stall");
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd7, 16'h00AA, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0);

    $display("[TB] pattern fill and full dump");
    for (int n = 1; n < 16; n++) begin
      applyStimulus(1'b1, 4'(n), 16'(n * 16'h0101), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    idleCycle(1'b1);
    repeat (17) idleCycle(1'b0);

    $display("[TB] request held across a scan, with reads during the dump");
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'(k), 1'b1, 4'(15 - k), 1'b0, 1'b1);
    end
    repeat (17) idleCycle(1'b0);

    $display("[TB] reset during a scan");
    idleCycle(1'b1);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      idleCycle(1'b0);
      if (dbg_vld && (lastIdx == 4'd6)) reached = 1'b1;
    end
    checkOutput("reached_word6", 32'(reached), 32'd1);
    resetPulse();
    repeat (20) idleCycle(1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 1'b0);
    idleCycle(1'b1);
    repeat (17) idleCycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The module SHALL have parameter R0_ZERO, default 1, meaning register 0 reads 0 and ignores writes when 1.
REQ-002 The module SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 The module SHALL have port we_DM_WB, input, 1, write-back enable.
REQ-005 The module SHALL have port dst_addr_DM_WB, input, 4, write-back register index.
REQ-006 The module SHALL have port rf_w_data_DM_WB, input, 16, write-back data from the write-back mux stage.
REQ-007 The module SHALL have ports p0_addr and p1_addr, input, 4 each, read indices from decode.
REQ-008 The module SHALL have ports re0 and re1, input, 1 each, read enables.
REQ-009 The module SHALL have port stall, input, 1, pipeline hold for the read outputs.
REQ-010 The module SHALL have ports p0 and p1, output, 16 each, registered read data to the ID/EX boundary.
REQ-011 The module SHALL have port dbg_req, input, 1, request for a full register dump.
REQ-012 The module SHALL have ports dbg_busy (output, 1, scan in progress), dbg_vld (output, 1, dump word valid), dbg_idx (output, 4, index of dump word) and dbg_data (output, 16, dump word).

Function
REQ-013 Storage SHALL be 16 x 16-bit registers.
REQ-014 The write SHALL occur at a rising edge when we_DM_WB=1, except that index 0 is not written when R0_ZERO=1.
REQ-015 Reads SHALL be registered, with p0 updated at a rising edge only when re0=1 and stall=0; otherwise p0 holds. p1 SHALL behave the same with re1.
REQ-016 The bypass rule SHALL apply to every read port: if a write per REQ-014 targets the read index on the same edge, the output takes rf_w_data_DM_WB, not the old contents.
REQ-017 When R0_ZERO=1, a read of index 0 SHALL return 0x0000 regardless of any write to index 0.
REQ-018 Writes SHALL proceed during stall; only p0 and p1 are held.
REQ-019 p0 and p1 SHALL both support reading the same index in the same cycle with identical results.
REQ-020 The dump FSM SHALL have two states, IDLE and SCAN, with dbg_busy=1 exactly while in SCAN (registered).
REQ-021 In IDLE, dbg_req=1 at a rising edge SHALL move the FSM to SCAN and clear the scan counter.
REQ-022 At each rising edge in SCAN, the FSM SHALL register dbg_vld=1, dbg_idx=counter and dbg_data=register[counter] with the REQ-016 bypass and REQ-017 zero rule applied, then increment the counter.
REQ-023 At the SCAN edge where counter=15, the FSM SHALL emit the last word and return to IDLE; at the next edge dbg_vld SHALL drop to 0.
REQ-024 Timing SHALL be as follows: with dbg_req sampled at edge E0, dbg_vld is high after edges E1 through E16 with dbg_idx 0 through 15 in order, and low after E17 unless a new scan started.
REQ-025 dbg_req SHALL be ignored while in SCAN, and a dbg_req present at the exit edge SHALL NOT start a new scan.
REQ-026 dbg_req high in IDLE on the edge right after a scan ends SHALL start a new scan, with no back-to-back gap requirement beyond that.
REQ-027 Dump operation SHALL NOT affect p0, p1 or writes.
REQ-028 dbg_data and dbg_idx SHALL hold their last values when dbg_vld=0.

Reset
REQ-029 rst=1 SHALL immediately clear all 16 registers, p0, p1, dbg_data, dbg_idx, dbg_vld, dbg_busy and the counter to 0, and force IDLE, asynchronously to clk.
REQ-030 Reset asserted mid-scan SHALL abort the scan, and no further dbg_vld SHALL appear until a new dbg_req after reset release.
REQ-031 Writes and reads SHALL be suppressed while rst=1.

Verification
REQ-032 The bench SHALL cover: write R3=0xBEEF, next cycle re0=1 p0_addr=3 -> p0=0xBEEF one edge later.
REQ-033 The bench SHALL cover: same-edge write R5=0x1234 with re1=1 p1_addr=5 -> p1=0x1234 after that edge (bypass).
REQ-034 The bench SHALL cover: R0_ZERO=1, write R0=0xFFFF then read R0 on both ports -> p0=p1=0x0000.
REQ-035 The bench SHALL cover: stall=1 with re0=1, p0_addr changed, write R7=0x00AA -> p0 held; stall released, read R7 -> p0=0x00AA.
REQ-036 The bench SHALL cover: Rn=n*0x0101 for n=1..15, dbg_req pulse -> 16 consecutive dbg_vld cycles with idx 0..15 and data 0x0000, 0x0101, ..., 0x0F0F, then dbg_busy=0.
REQ-037 The bench SHALL cover: rst pulse at scan word 6 -> dbg_vld=0, dbg_busy=0 and all registers 0x0000 immediately, with no further dump words.
